// File: rtl/mdio_peripheral.sv
// PHY-side MDIO (Clause 22) responder. MDC/MDIO are sampled in the clk domain; decoded
// frames become one-clk write/read strobes on a simple synchronous register port.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        MEMORY_WR,
  output logic        MEMORY_RD,
  input  logic [15:0] RD_DATA
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] READ   = 3'd3;
  localparam logic [2:0] SKIP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [12:0] hdr_q, hdr_d;
  logic [15:0] data_q, data_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        mdio_in_q, mdio_in_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        cap_q, cap_d;
  logic        mdc_q;

  logic        rise, fall;
  logic [13:0] hdr_shift;
  logic [15:0] data_shift;

  assign rise       = MDC & ~mdc_q;
  assign fall       = ~MDC & mdc_q;
  assign hdr_shift  = {hdr_q, MDIO_OUT};
  assign data_shift = {data_q[14:0], MDIO_OUT};

  // cnt_q holds the number of the last rising edge seen in the frame (r1 -> 1).
  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    mdio_in_d = 1'b0;
    mem_wr_d  = 1'b0;
    mem_rd_d  = 1'b0;
    cap_d     = mem_rd_q;

    if (cap_q) data_d = RD_DATA;

    case (state_q)
      IDLE: begin
        if (rise && MDIO_OE) begin
          hdr_d   = {12'd0, MDIO_OUT};
          cnt_d   = 6'd1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (rise) begin
          if (!MDIO_OE) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
          end else begin
            hdr_d = hdr_shift[12:0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd13) begin
              addr_d = hdr_shift[4:0];
              if (hdr_shift[13:12] != 2'b01 || hdr_shift[9:5] != PHY_ADDR) begin
                state_d = SKIP;
              end else if (hdr_shift[11:10] == 2'b10) begin
                state_d  = READ;
                mem_rd_d = 1'b1;
              end else if (hdr_shift[11:10] == 2'b01) begin
                state_d = WRITE;
              end else begin
                state_d = SKIP;
              end
            end
          end
        end
      end
      WRITE: begin
        if (rise) begin
          if (cnt_q < 6'd16) begin
            cnt_d = cnt_q + 6'd1;
          end else if (!MDIO_OE) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
          end else if (cnt_q == 6'd31) begin
            wr_data_d = data_shift;
            mem_wr_d  = 1'b1;
            state_d   = IDLE;
            cnt_d     = 6'd0;
          end else begin
            data_d = data_shift;
            cnt_d  = cnt_q + 6'd1;
          end
        end
      end
      READ: begin
        mdio_in_d = mdio_in_q;
        if (rise && cnt_q < 6'd32) begin
          cnt_d = cnt_q + 6'd1;
        end else if (fall && cnt_q >= 6'd16) begin
          // Bits leave on falls so the controller sees them stable at the next rise.
          if (cnt_q == 6'd32) begin
            mdio_in_d = 1'b0;
            state_d   = IDLE;
            cnt_d     = 6'd0;
          end else begin
            mdio_in_d = data_q[15];
            data_d    = {data_q[14:0], 1'b0};
          end
        end
      end
      SKIP: begin
        if (rise) begin
          if (cnt_q == 6'd31) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      hdr_q     <= 13'd0;
      data_q    <= 16'd0;
      addr_q    <= 5'd0;
      wr_data_q <= 16'd0;
      mdio_in_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      cap_q     <= 1'b0;
      mdc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      mdio_in_q <= mdio_in_d;
      mem_wr_q  <= mem_wr_d;
      mem_rd_q  <= mem_rd_d;
      cap_q     <= cap_d;
      mdc_q     <= MDC;
    end
  end

  assign MDIO_IN   = mdio_in_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign MEMORY_WR = mem_wr_q;
  assign MEMORY_RD = mem_rd_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Bench for mdio_peripheral: directed frame table, hand sequences for reset/abort cases,
// then random frames checked against a per-frame behavioural model.
module tb_mdio_peripheral;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rbits;
  } exp_t;

  typedef struct {
    logic [31:0] frame;
    int          drop;
    exp_t        exp;
  } vec_t;

  localparam logic [4:0] PHY0 = 5'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        MDC, MDIO_OUT, MDIO_OE;
  logic        MDIO_IN, MEMORY_WR, MEMORY_RD;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA, RD_DATA;
  logic        MDIO_IN1, MEMORY_WR1, MEMORY_RD1;
  logic [4:0]  ADDR1;
  logic [15:0] WR_DATA1;
  logic [15:0] RD_DATA1 = 16'h0000;

  mdio_peripheral #(.PHY_ADDR(5'd0)) dut (
    .clk(clk), .rst(rst), .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
    .MDIO_IN(MDIO_IN), .ADDR(ADDR), .WR_DATA(WR_DATA), .MEMORY_WR(MEMORY_WR),
    .MEMORY_RD(MEMORY_RD), .RD_DATA(RD_DATA)
  );

  mdio_peripheral #(.PHY_ADDR(5'd1)) dut1 (
    .clk(clk), .rst(rst), .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
    .MDIO_IN(MDIO_IN1), .ADDR(ADDR1), .WR_DATA(WR_DATA1), .MEMORY_WR(MEMORY_WR1),
    .MEMORY_RD(MEMORY_RD1), .RD_DATA(RD_DATA1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seed(input logic [4:0] a);
    return 16'hA5C3 ^ (16'(a) * 16'd1237);
  endfunction

  // Register file on the far side of the memory port; read data appears the clk after MEMORY_RD.
  bit [15:0] mem [32];
  bit        written [32];
  always @(posedge clk) begin
    if (MEMORY_WR) begin
      mem[ADDR]     <= WR_DATA;
      written[ADDR] <= 1'b1;
    end
    if (MEMORY_RD) RD_DATA <= written[ADDR] ? mem[ADDR] : seed(ADDR);
  end

  // Cycle monitor, sampled 1 time unit after each rising clk edge.
  int   rise_total = 0, wr_total = 0, rd_total = 0, wr1_total = 0, rd1_total = 0;
  int   viol_total = 0, wr_at = -1, rd_at = -1;
  bit   mdc_prev = 1'b0, rise_here, fall_here;
  logic mdio_prev = 1'b0;
  bit   rd_window = 1'b0;

  always @(posedge clk) begin
    #1;
    rise_here = MDC && !mdc_prev;
    fall_here = !MDC && mdc_prev;
    mdc_prev  = MDC;
    if (rise_here) rise_total++;
    if (MEMORY_WR) begin
      wr_total++;
      wr_at = rise_here ? rise_total : -1;
    end
    if (MEMORY_RD) begin
      rd_total++;
      rd_at = rise_here ? rise_total : -1;
    end
    if (MEMORY_WR1) wr1_total++;
    if (MEMORY_RD1) rd1_total++;
    if (!rst) begin
      if (!rd_window && MDIO_IN !== 1'b0) viol_total++;
      if (MDIO_IN !== mdio_prev && !fall_here) viol_total++;
    end
    mdio_prev = MDIO_IN;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Behavioural model: whole-frame effect from the field values.
  logic [15:0] model_mem [32];
  logic [4:0]  model_addr  = 5'd0;
  logic [15:0] model_wdata = 16'd0;

  task automatic model_frame(input logic [31:0] f, input int drop, output exp_t e);
    e.wr    = 1'b0;
    e.rd    = 1'b0;
    e.rbits = 16'd0;
    if (drop == 0 || drop > 14) begin
      model_addr = f[22:18];
      if (f[31:30] == 2'b01 && f[27:23] == PHY0) begin
        if (f[29:28] == 2'b01 && drop == 0) begin
          model_wdata           = f[15:0];
          model_mem[f[22:18]]   = f[15:0];
          e.wr                  = 1'b1;
        end else if (f[29:28] == 2'b10) begin
          e.rd    = 1'b1;
          e.rbits = model_mem[f[22:18]];
        end
      end
    end
    e.addr  = model_addr;
    e.wdata = model_wdata;
  endtask

  logic rbits_seen [1:32];

  // Entered and left on a negedge; the controller samples MDIO_IN just before raising MDC.
  task automatic send_bit(input logic oe, input logic d, input int r, input int mx);
    rbits_seen[r] = MDIO_IN;
    MDIO_OE  = oe;
    MDIO_OUT = d;
    MDC      = 1'b1;
    repeat ($urandom_range(1, mx)) @(negedge clk);
    MDC = 1'b0;
    repeat ($urandom_range(1, mx)) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] f, input int drop, input bit rand_tail,
                           input int mx, input int idx, input exp_t e);
    bit          valid, valid_wr, valid_rd;
    logic        oe;
    logic [15:0] got;
    int          rise_base, wr_base, rd_base, viol_base;
    valid     = (f[31:30] == 2'b01) && (f[27:23] == PHY0);
    valid_wr  = valid && f[29:28] == 2'b01;
    valid_rd  = valid && f[29:28] == 2'b10;
    rise_base = rise_total;
    wr_base   = wr_total;
    rd_base   = rd_total;
    viol_base = viol_total;
    rd_window = valid_rd && drop == 0;
    for (int r = 1; r <= 32; r++) rbits_seen[r] = 1'b0;
    for (int r = 1; r <= 32; r++) begin
      if (r <= 14 || valid_wr) oe = 1'b1;
      else if (valid_rd)       oe = 1'b0;
      else                     oe = rand_tail ? 1'($urandom) : 1'b0;
      if (r == drop) oe = 1'b0;
      send_bit(oe, f[32-r], r, mx);
      if (r == drop) break;
    end
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b0;
    for (int k = 0; k < 16; k++) got[15-k] = rbits_seen[17+k];

    check("wr_count", idx, wr_total - wr_base, 32'(e.wr));
    if (e.wr) check("wr_at_r32", idx, wr_at - rise_base, 32);
    check("rd_count", idx, rd_total - rd_base, 32'(e.rd));
    if (e.rd) begin
      check("rd_at_r14", idx, rd_at - rise_base, 14);
      check("rd_bits", idx, 32'(got), 32'(e.rbits));
    end
    check("addr", idx, 32'(ADDR), 32'(e.addr));
    check("wr_data", idx, 32'(WR_DATA), 32'(e.wdata));
    check("mdio_in_after", idx, 32'(MDIO_IN), 0);
    check("mdio_in_timing", idx, viol_total - viol_base, 0);
    rd_window = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] f, input int drop, input bit wr, input bit rd,
                              input logic [4:0] a, input logic [15:0] wd, input logic [15:0] rb);
    vec_t v;
    v.frame     = f;
    v.drop      = drop;
    v.exp.wr    = wr;
    v.exp.rd    = rd;
    v.exp.addr  = a;
    v.exp.wdata = wd;
    v.exp.rbits = rb;
    return v;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    exp_t em;
    vecs[0] = mk(32'h5016BEEF, 0, 1, 0, 5'd5,  16'hBEEF, 16'h0000);
    vecs[1] = mk(32'h60140000, 0, 0, 1, 5'd5,  16'hBEEF, 16'hBEEF);
    vecs[2] = mk(32'h8A5AFF01, 0, 0, 0, 5'd22, 16'hBEEF, 16'h0000);
    vecs[3] = mk(32'h5016BEEF, 0, 1, 0, 5'd5,  16'hBEEF, 16'h0000);
    vecs[4] = mk(32'h501A1234, 8, 0, 0, 5'd5,  16'hBEEF, 16'h0000);
    vecs[5] = mk(32'h501A1234, 0, 1, 0, 5'd6,  16'h1234, 16'h0000);
    vecs[6] = mk(32'h60180000, 0, 0, 1, 5'd6,  16'h1234, 16'h1234);
    vecs[7] = mk(32'h40160000, 0, 0, 0, 5'd5,  16'h1234, 16'h0000);

    for (int i = 0; i < 32; i++) model_mem[i] = seed(5'(i));

    rst = 1'b1; MDC = 1'b0; MDIO_OUT = 1'b0; MDIO_OE = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mdio_in", 0, 32'(MDIO_IN), 0);
    check("reset_addr", 0, 32'(ADDR), 0);
    check("reset_wr_data", 0, 32'(WR_DATA), 0);
    check("reset_memory_wr", 0, 32'(MEMORY_WR), 0);
    check("reset_memory_rd", 0, 32'(MEMORY_RD), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      model_frame(vecs[i].frame, vecs[i].drop, em);
      run_frame(vecs[i].frame, vecs[i].drop, 1'b0, (i % 2 == 0) ? 1 : 3, i, vecs[i].exp);
      repeat (i % 2) @(negedge clk);
    end

    check("phy1_wr_count", 0, wr1_total, 0);
    check("phy1_rd_count", 0, rd1_total, 0);
    check("phy1_wr_data", 0, 32'(WR_DATA1), 0);

    // Reset in the middle of a write, right after r20.
    begin
      int   wr_base;
      logic [31:0] f;
      f       = 32'h5016CAFE;
      wr_base = wr_total;
      for (int r = 1; r <= 20; r++) send_bit(1'b1, f[32-r], r, 2);
      rst = 1'b1;
      #1;
      check("midreset_mdio_in", 50, 32'(MDIO_IN), 0);
      check("midreset_addr", 50, 32'(ADDR), 0);
      check("midreset_wr_data", 50, 32'(WR_DATA), 0);
      check("midreset_memory_wr", 50, 32'(MEMORY_WR), 0);
      check("midreset_memory_rd", 50, 32'(MEMORY_RD), 0);
      repeat (2) @(negedge clk);
      MDC = 1'b0; MDIO_OE = 1'b0;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("midreset_no_write", 50, wr_total - wr_base, 0);
      model_addr  = 5'd0;
      model_wdata = 16'd0;
      model_frame(32'h5016BEEF, 0, em);
      run_frame(32'h5016BEEF, 0, 1'b0, 2, 51, em);
    end

    for (int n = 0; n < 60; n++) begin
      logic [31:0] f;
      int          drop;
      exp_t        e;
      f[31:30] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b01;
      case ($urandom_range(0, 7))
        0, 1, 2: f[29:28] = 2'b01;
        3, 4, 5: f[29:28] = 2'b10;
        6:       f[29:28] = 2'b00;
        default: f[29:28] = 2'b11;
      endcase
      f[27:23] = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      f[22:18] = 5'($urandom);
      f[17:16] = 2'b10;
      f[15:0]  = 16'($urandom);
      drop = 0;
      if ($urandom_range(0, 5) == 0)
        drop = int'($urandom_range(1, 14));
      else if (f[31:30] == 2'b01 && f[29:28] == 2'b01 && f[27:23] == PHY0 &&
               $urandom_range(0, 4) == 0)
        drop = int'($urandom_range(17, 32));
      model_frame(f, drop, e);
      run_frame(f, drop, 1'b1, 3, 100 + n, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdio_peripheral.md
# mdio_peripheral

Management-side responder for the MDIO serial interface: the PHY end of the link driven by the team's MDIO controller. It samples MDC/MDIO_OUT/MDIO_OE from the controller, decodes 32-bit Clause-22 frames, and performs register writes or reads through a simple synchronous memory port. On reads it shifts register data back to the controller on MDIO_IN.

## Interface
- PHY_ADDR, 5'd0, PHY address this peripheral answers to.
- clk  input  1  system clock; MDC is generated synchronously to it by the controller.
- rst  input  1  asynchronous, active-high reset.
- MDC  input  1  management clock from controller (sampled in clk domain).
- MDIO_OUT  input  1  serial data from controller.
- MDIO_OE  input  1  controller drive enable; 1 = controller owns the line.
- MDIO_IN  output  1  serial read data to controller.
- ADDR  output  5  register address (REGADR field).
- WR_DATA  output  16  write data.
- MEMORY_WR  output  1  one-clk write strobe.
- MEMORY_RD  output  1  one-clk read strobe.
- RD_DATA  input  16  read data, valid the clk after MEMORY_RD.

## Operation
- Frame (MSB first, 32 bits): ST[31:30]=01, OP[29:28] (01 write, 10 read), PHYADR[27:23], REGADR[22:18], TA[17:16], DATA[15:0].
- Edge detect: mdc_q = MDC registered; rise = MDC & ~mdc_q, fall = ~MDC & mdc_q. Actions occur on the clk edge where rise/fall is true; MDIO_OUT/MDIO_OE sampled on that same edge.
- Rising edges numbered r1..r32 within a frame; 5-bit-plus bit counter.
- States:
  - IDLE: rise with MDIO_OE=1 samples bit 31, counter=1, -> HEADER. Rise with MDIO_OE=0 ignored.
  - HEADER: shift bits on r2..r14 (MDIO_OE must be 1; rise with MDIO_OE=0 -> IDLE, no access). At r14: ADDR <= REGADR; check ST=01, OP in {01,10}, PHYADR=PHY_ADDR; any fail -> SKIP. OP=10 -> READ (MEMORY_RD pulses the clk after r14). OP=01 -> WRITE.
  - WRITE: r15,r16 (TA) counted, values ignored; r17..r32 shift DATA with MDIO_OE=1 required (else -> IDLE, no write). After r32: WR_DATA <= DATA, MEMORY_WR=1 for exactly one clk, then IDLE.
  - READ: RD_DATA captured into shift register the clk after MEMORY_RD. r15,r16 counted regardless of MDIO_OE. On the fall following r16, MDIO_IN <= data[15]; each subsequent fall shifts next bit, so controller samples bit 15-k at r(17+k). On the fall after r32, MDIO_IN <= 0, -> IDLE.
  - SKIP: count rises to r32 regardless of MDIO_OE, no strobes, MDIO_IN=0, then IDLE.
- Only one of MEMORY_WR/MEMORY_RD ever asserted; each at most once per frame.

## Timing
- Reset values: MDIO_IN=0, ADDR=0, WR_DATA=0, MEMORY_WR=0, MEMORY_RD=0, state IDLE, counter 0, mdc_q=0.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values; partial frame discarded, no strobe after release.
- MEMORY_RD: high exactly the clk after r14 detection; RD_DATA latched on following clk edge; ADDR stable from r14 until next frame's r14.
- MEMORY_WR: high exactly the clk after r32 detection; WR_DATA/ADDR stable while high and held until overwritten.
- MDIO_IN changes only on fall edges in READ; 0 in every other state.
- Back-to-back frames: rise with MDIO_OE=1 on the clk after returning to IDLE starts a new frame.
- Minimum supported MDC period: 2 clk (one high, one low).

## Test plan
- Write: frame 0x5016BEEF (REG 5), PHY_ADDR=0 -> MEMORY_WR one clk after r32, ADDR=5, WR_DATA=0xBEEF; MEMORY_RD never asserted.
- Read: frame header 0x6014, MDIO_OE=0 from r15, RD_DATA=0xBEEF -> MEMORY_RD one clk after r14, ADDR=5; MDIO_IN sampled at r17..r32 = 1011111011101111; MDIO_IN=0 after.
- Invalid ST: frame 0x8A5AFF01 -> SKIP, no strobes, MDIO_IN=0 throughout, IDLE after r32; following 0x5016BEEF write succeeds.
- PHY mismatch: PHY_ADDR=1, frame 0x5016BEEF -> no MEMORY_WR, WR_DATA unchanged.
- Reset mid-frame: assert rst at r20 of write 0x5016BEEF -> all outputs 0 immediately, no MEMORY_WR after release; next valid frame processed normally.
- OE drop: MDIO_OE=0 at r8 of a write -> IDLE, no strobes; next frame decoded from its r1.
